ram_req_tag_router: RTL and testbench

Single-clock, parametrised successor to the RAM clock-crossing bridge. It merges pChannels independent RAM request ports into one downstream request stream using round-robin arbitration. It tags every accepted read with its channel ID in an internal tag FIFO, and routes in-order read data from memory back to the requesting channel. It sits between the UFI-side clients and the RAM controller, in the system clock domain, ahead of any clock-crossing FIFO.

---
 rtl/ram_req_tag_router.sv | 144 ++++++++++++++
 tb/tb_ram_req_tag_router.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_tag_router.sv
// Round-robin merge of N RAM request ports into one stream, with an
// in-order read-tag FIFO that steers returned data to its requester.
module ram_req_tag_router #(
    parameter int pChannels     = 4,
    parameter int pRamDqWidth   = 8,
    parameter int pRamAdrsWidth = 19,
    parameter int pTagDepth     = 16,
    localparam int lpIdWidth    = (pChannels > 1) ? $clog2(pChannels) : 1,
    localparam int lpCntWidth   = $clog2(pTagDepth) + 1,
    localparam int lpPtrWidth   = (pTagDepth > 1) ? $clog2(pTagDepth) : 1
) (
    input  logic                               iCLK,
    input  logic                               iRST,
    input  logic [pChannels-1:0]               iChReq,
    input  logic [pChannels-1:0]               iChCmd,
    input  logic [pChannels*pRamAdrsWidth-1:0] iChAdrs,
    input  logic [pChannels*pRamDqWidth-1:0]   iChWd,
    output logic [pChannels-1:0]               oChGnt,
    output logic                               oVd,
    output logic                               oCmd,
    output logic [pRamAdrsWidth-1:0]           oAdrs,
    output logic [pRamDqWidth-1:0]             oWd,
    input  logic                               iRdy,
    input  logic [pRamDqWidth-1:0]             iMemRd,
    input  logic                               iMemRVd,
    output logic [pRamDqWidth-1:0]             oRd,
    output logic [pChannels-1:0]               oChRVd,
    output logic [lpCntWidth-1:0]              oTagCnt,
    output logic                               oTagFull,
    output logic                               oErr
);

    logic                     vd_q, vd_d;
    logic                     cmd_q;
    logic [pRamAdrsWidth-1:0] adrs_q;
    logic [pRamDqWidth-1:0]   wd_q;
    logic [pRamDqWidth-1:0]   rd_q;
    logic [pChannels-1:0]     chrvd_q, chrvd_d;
    logic [lpCntWidth-1:0]    cnt_q, cnt_d;
    logic                     err_q;
    logic [lpIdWidth-1:0]     ptr_q, ptr_d;
    logic [lpPtrWidth-1:0]    wptr_q, rptr_q;
    logic [lpIdWidth-1:0]     tag_q [pTagDepth];

    logic                     full, pop, push, load_ok, tag_ok, found;
    logic [pChannels-1:0]     elig, gnt;
    logic [lpIdWidth-1:0]     gnt_id, idx_id, pop_id;
    int                       idx;

    assign full    = (cnt_q == lpCntWidth'(pTagDepth));
    assign pop     = iMemRVd & (cnt_q != '0);
    assign load_ok = ~vd_q | iRdy;
    // A pop in this cycle frees a slot, so a read may push into a full FIFO.
    assign tag_ok  = ~full | pop;
    assign elig    = iChReq & (~iChCmd | {pChannels{tag_ok}});
    assign pop_id  = tag_q[rptr_q];

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx_id = '0;
        idx    = 0;
        found  = 1'b0;
        if (iRST && load_ok) begin
            for (int i = 0; i < pChannels; i++) begin
                idx    = (int'(ptr_q) + i) % pChannels;
                idx_id = lpIdWidth'(idx);
                if (!found && elig[idx_id]) begin
                    found  = 1'b1;
                    gnt_id = idx_id;
                end
            end
        end
        if (found) gnt[gnt_id] = 1'b1;
    end

    assign push = found & iChCmd[gnt_id];

    always_comb begin
        ptr_d = ptr_q;
        if (found)
            ptr_d = (gnt_id == lpIdWidth'(pChannels - 1)) ? '0
                  : gnt_id + lpIdWidth'(1);
        vd_d = vd_q;
        if (found)     vd_d = 1'b1;
        else if (iRdy) vd_d = 1'b0;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + lpCntWidth'(1);
        else if (!push && pop) cnt_d = cnt_q - lpCntWidth'(1);
        chrvd_d = '0;
        if (pop) chrvd_d[pop_id] = 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            vd_q    <= 1'b0;
            cmd_q   <= 1'b0;
            adrs_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            chrvd_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            vd_q    <= vd_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            chrvd_q <= chrvd_d;
            if (found) begin
                cmd_q  <= iChCmd[gnt_id];
                adrs_q <= iChAdrs[gnt_id*pRamAdrsWidth +: pRamAdrsWidth];
                wd_q   <= iChWd[gnt_id*pRamDqWidth +: pRamDqWidth];
            end
            if (push)
                wptr_q <= (wptr_q == lpPtrWidth'(pTagDepth - 1)) ? '0
                        : wptr_q + lpPtrWidth'(1);
            if (pop) begin
                rd_q   <= iMemRd;
                rptr_q <= (rptr_q == lpPtrWidth'(pTagDepth - 1)) ? '0
                        : rptr_q + lpPtrWidth'(1);
            end
            if (iMemRVd && !pop) err_q <= 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) tag_q[wptr_q] <= gnt_id;
    end

    assign oChGnt   = gnt;
    assign oVd      = vd_q;
    assign oCmd     = cmd_q;
    assign oAdrs    = adrs_q;
    assign oWd      = wd_q;
    assign oRd      = rd_q;
    assign oChRVd   = chrvd_q;
    assign oTagCnt  = cnt_q;
    assign oTagFull = full;
    assign oErr     = err_q;

endmodule

// File: tb/tb_ram_req_tag_router.sv
// Directed bench for ram_req_tag_router: vector table for arbitration and
// backpressure, hand sequences for tag-full, routing and error handling.
module tb_ram_req_tag_router;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int AW  = 19;
    localparam int TD  = 4;
    localparam int CW  = $clog2(TD) + 1;

    logic                iCLK = 1'b0;
    logic                iRST;
    logic [NCH-1:0]      iChReq, iChCmd;
    logic [NCH*AW-1:0]   iChAdrs;
    logic [NCH*DW-1:0]   iChWd;
    logic [NCH-1:0]      oChGnt;
    logic                oVd, oCmd;
    logic [AW-1:0]       oAdrs;
    logic [DW-1:0]       oWd;
    logic                iRdy;
    logic [DW-1:0]       iMemRd;
    logic                iMemRVd;
    logic [DW-1:0]       oRd;
    logic [NCH-1:0]      oChRVd;
    logic [CW-1:0]       oTagCnt;
    logic                oTagFull, oErr;

    int n_cmp = 0;
    int n_bad = 0;

    ram_req_tag_router #(
        .pChannels(NCH), .pRamDqWidth(DW),
        .pRamAdrsWidth(AW), .pTagDepth(TD)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iChReq(iChReq), .iChCmd(iChCmd),
        .iChAdrs(iChAdrs), .iChWd(iChWd),
        .oChGnt(oChGnt), .oVd(oVd), .oCmd(oCmd),
        .oAdrs(oAdrs), .oWd(oWd), .iRdy(iRdy),
        .iMemRd(iMemRd), .iMemRVd(iMemRVd),
        .oRd(oRd), .oChRVd(oChRVd), .oTagCnt(oTagCnt),
        .oTagFull(oTagFull), .oErr(oErr)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [NCH-1:0] req;
        logic [NCH-1:0] cmd;
        logic           rdy;
        logic [NCH-1:0] gnt;
        logic           vd;
        logic [AW-1:0]  adrs;
        logic [DW-1:0]  wd;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) begin
            iChAdrs[k*AW +: AW] = AW'(32'h100 + k);
            iChWd[k*DW +: DW]   = DW'(32'h10 + k);
        end
        iRST = 1'b0; iChReq = '1; iChCmd = '0;
        iRdy = 1'b1; iMemRd = '0; iMemRVd = 1'b0;

        // Reset: all requesting, no grants, outputs at reset values
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_gnt", 32'(oChGnt), 0);
            chk("rst_vd", 32'(oVd), 0);
            chk("rst_adrs", 32'(oAdrs), 0);
            chk("rst_wd", 32'(oWd), 0);
            chk("rst_cnt", 32'(oTagCnt), 0);
            chk("rst_full", 32'(oTagFull), 0);
            chk("rst_rvd", 32'(oChRVd), 0);
            chk("rst_rd", 32'(oRd), 0);
            chk("rst_err", 32'(oErr), 0);
            chk("rst_cmd", 32'(oCmd), 0);
        end
        iRST = 1'b1;

        // Round robin, then single write under backpressure
        tbl[0]  = '{4'hF, 4'h0, 1'b1, 4'h1, 1'b1, 19'h100, 8'h10};
        tbl[1]  = '{4'hF, 4'h0, 1'b1, 4'h2, 1'b1, 19'h101, 8'h11};
        tbl[2]  = '{4'hF, 4'h0, 1'b1, 4'h4, 1'b1, 19'h102, 8'h12};
        tbl[3]  = '{4'hF, 4'h0, 1'b1, 4'h8, 1'b1, 19'h103, 8'h13};
        tbl[4]  = '{4'hF, 4'h0, 1'b1, 4'h1, 1'b1, 19'h100, 8'h10};
        tbl[5]  = '{4'hF, 4'h0, 1'b1, 4'h2, 1'b1, 19'h101, 8'h11};
        tbl[6]  = '{4'h1, 4'h0, 1'b1, 4'h1, 1'b1, 19'h100, 8'h10};
        for (int i = 7; i < 12; i++)
            tbl[i] = '{4'h1, 4'h0, 1'b0, 4'h0, 1'b1, 19'h100, 8'h10};
        tbl[12] = '{4'h1, 4'h0, 1'b1, 4'h1, 1'b1, 19'h100, 8'h10};
        tbl[13] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 19'h0, 8'h0};

        for (int i = 0; i < 14; i++) begin
            iChReq = tbl[i].req;
            iChCmd = tbl[i].cmd;
            iRdy   = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(oChGnt), 32'(tbl[i].gnt));
            tick();
            chk($sformatf("v%0d_vd", i), 32'(oVd), 32'(tbl[i].vd));
            if (tbl[i].vd) begin
                chk($sformatf("v%0d_adrs", i), 32'(oAdrs),
                    32'(tbl[i].adrs));
                chk($sformatf("v%0d_wd", i), 32'(oWd), 32'(tbl[i].wd));
            end
        end

        // Tag full: channel 2 reads fill the FIFO, channel 1 write passes
        iRdy = 1'b1;
        iChReq = 4'b0100; iChCmd = 4'b0100;
        for (int r = 0; r < 4; r++) begin
            #1;
            chk($sformatf("rd%0d_gnt", r), 32'(oChGnt), 32'h4);
            tick();
        end
        chk("full_cnt", 32'(oTagCnt), 4);
        chk("full_flag", 32'(oTagFull), 1);
        chk("full_cmd", 32'(oCmd), 1);
        chk("full_adrs", 32'(oAdrs), 32'h102);
        iChReq = 4'b0110;
        #1;
        chk("wr_past_full", 32'(oChGnt), 32'h2);
        tick();
        chk("wr_cmd", 32'(oCmd), 0);
        chk("wr_adrs", 32'(oAdrs), 32'h101);
        iChReq = 4'b0100;
        #1;
        chk("rd5_blocked", 32'(oChGnt), 0);
        tick();
        iMemRVd = 1'b1; iMemRd = 8'hA5;
        #1;
        chk("rd5_gnt_on_pop", 32'(oChGnt), 32'h4);
        tick();
        chk("pop_rvd", 32'(oChRVd), 32'h4);
        chk("pop_rd", 32'(oRd), 32'hA5);
        chk("pop_cnt", 32'(oTagCnt), 4);
        iChReq = '0;
        for (int r = 0; r < 4; r++) begin
            iMemRd = DW'(32'hC0 + r);
            tick();
            chk($sformatf("drain%0d_rvd", r), 32'(oChRVd), 32'h4);
            chk($sformatf("drain%0d_rd", r), 32'(oRd), 32'hC0 + r);
        end
        iMemRVd = 1'b0;
        tick();
        chk("drain_cnt", 32'(oTagCnt), 0);
        chk("drain_rvd", 32'(oChRVd), 0);
        chk("drain_err", 32'(oErr), 0);

        // Routing: reads from 3, 0, 3 returned in order
        iChReq = 4'b1000; iChCmd = 4'b1000;
        #1; chk("rt0_gnt", 32'(oChGnt), 32'h8); tick();
        iChReq = 4'b0001; iChCmd = 4'b0001;
        #1; chk("rt1_gnt", 32'(oChGnt), 32'h1); tick();
        iChReq = 4'b1000; iChCmd = 4'b1000;
        #1; chk("rt2_gnt", 32'(oChGnt), 32'h8); tick();
        iChReq = '0;
        chk("rt_cnt3", 32'(oTagCnt), 3);
        iMemRVd = 1'b1;
        iMemRd = 8'h11; tick();
        chk("rt_rvd0", 32'(oChRVd), 32'h8); chk("rt_rd0", 32'(oRd), 32'h11);
        iMemRd = 8'h22; tick();
        chk("rt_rvd1", 32'(oChRVd), 32'h1); chk("rt_rd1", 32'(oRd), 32'h22);
        iMemRd = 8'h33; tick();
        chk("rt_rvd2", 32'(oChRVd), 32'h8); chk("rt_rd2", 32'(oRd), 32'h33);
        iMemRVd = 1'b0;
        tick();
        chk("rt_cnt0", 32'(oTagCnt), 0);
        chk("rt_idle_rvd", 32'(oChRVd), 0);

        // Error: return with no outstanding tag
        iMemRVd = 1'b1; iMemRd = 8'h55;
        tick();
        iMemRVd = 1'b0;
        chk("err_set", 32'(oErr), 1);
        chk("err_rvd", 32'(oChRVd), 0);
        chk("err_cnt", 32'(oTagCnt), 0);
        chk("err_rd_hold", 32'(oRd), 32'h33);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("err_sticky", 32'(oErr), 1);
        end
        iRST = 1'b0;
        tick();
        chk("err_clr", 32'(oErr), 0);
        chk("err_clr_rd", 32'(oRd), 0);
        iRST = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
